// File: rtl/tt_pad_cfg_seq.sv
// rtl/tt_pad_cfg_seq.sv - staged GPIO pad-control sequencer with break-before-make commit
// Define TT_PAD_SEQ_GUARD_EN to build the guarded OFF/WAIT1/CFG/WAIT2 sequence; otherwise commit applies in one edge.
module tt_pad_cfg_seq #(
  parameter int NUM_PADS     = 8,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [3:0]          cfg_addr,
  input  logic [5:0]          cfg_wdata,
  input  logic                commit,
  output logic                busy,
  output logic                done,
  output logic [NUM_PADS-1:0] pad_oe,
  output logic [NUM_PADS-1:0] pad_ie,
  output logic [NUM_PADS-1:0] pad_sl,
  output logic [NUM_PADS-1:0] pad_cs,
  output logic [NUM_PADS-1:0] pad_pd,
  output logic [NUM_PADS-1:0] pad_pu
);

  localparam logic [5:0] STG_RST = 6'b000010;

  logic [5:0]          stg_q [NUM_PADS];
  logic [5:0]          stg_d [NUM_PADS];
  logic [NUM_PADS-1:0] oe_q, oe_d, ie_q, ie_d, sl_q, sl_d;
  logic [NUM_PADS-1:0] cs_q, cs_d, pd_q, pd_d, pu_q, pu_d;
  logic [NUM_PADS-1:0] st_oe, st_ie, st_sl, st_cs, st_pd, st_pu;
  logic                done_q, done_d;
  logic                wr_en;

  assign wr_en = cfg_valid & cfg_ready;

  // Same-cycle write is folded in so a commit sees it; out-of-range addresses match no pad.
  always_comb begin
    for (int i = 0; i < NUM_PADS; i++) begin
      stg_d[i] = stg_q[i];
      if (wr_en && (cfg_addr == i[3:0])) begin
        stg_d[i] = cfg_wdata;
      end
      st_oe[i] = stg_d[i][0];
      st_ie[i] = stg_d[i][1];
      st_sl[i] = stg_d[i][2];
      st_cs[i] = stg_d[i][3];
      st_pd[i] = stg_d[i][4];
      st_pu[i] = stg_d[i][5];
    end
  end

`ifdef TT_PAD_SEQ_GUARD_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_OFF   = 3'd1,
    ST_WAIT1 = 3'd2,
    ST_CFG   = 3'd3,
    ST_WAIT2 = 3'd4
  } state_t;

  localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYCLES);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    oe_d    = oe_q;
    ie_d    = ie_q;
    sl_d    = sl_q;
    cs_d    = cs_q;
    pd_d    = pd_q;
    pu_d    = pu_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (commit) begin
          state_d = ST_OFF;
          oe_d    = oe_q & st_oe;
        end
      end
      ST_OFF: begin
        state_d = ST_WAIT1;
        cnt_d   = GUARD_LOAD;
      end
      ST_WAIT1: begin
        if (cnt_q == 4'd1) begin
          state_d = ST_CFG;
          cnt_d   = 4'd0;
          ie_d    = st_ie;
          sl_d    = st_sl;
          cs_d    = st_cs;
          pd_d    = st_pd;
          pu_d    = st_pu;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_CFG: begin
        state_d = ST_WAIT2;
        cnt_d   = GUARD_LOAD;
      end
      ST_WAIT2: begin
        if (cnt_q == 4'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          oe_d    = st_oe;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cfg_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
`else
  always_comb begin
    oe_d   = oe_q;
    ie_d   = ie_q;
    sl_d   = sl_q;
    cs_d   = cs_q;
    pd_d   = pd_q;
    pu_d   = pu_q;
    done_d = 1'b0;
    if (commit) begin
      oe_d   = st_oe;
      ie_d   = st_ie;
      sl_d   = st_sl;
      cs_d   = st_cs;
      pd_d   = st_pd;
      pu_d   = st_pu;
      done_d = 1'b1;
    end
  end

  assign cfg_ready = 1'b1;
  assign busy      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PADS; i++) begin
        stg_q[i] <= STG_RST;
      end
      oe_q   <= '0;
      ie_q   <= '1;
      sl_q   <= '0;
      cs_q   <= '0;
      pd_q   <= '0;
      pu_q   <= '0;
      done_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_PADS; i++) begin
        stg_q[i] <= stg_d[i];
      end
      oe_q   <= oe_d;
      ie_q   <= ie_d;
      sl_q   <= sl_d;
      cs_q   <= cs_d;
      pd_q   <= pd_d;
      pu_q   <= pu_d;
      done_q <= done_d;
    end
  end

  assign pad_oe = oe_q;
  assign pad_ie = ie_q;
  assign pad_sl = sl_q;
  assign pad_cs = cs_q;
  assign pad_pd = pd_q;
  assign pad_pu = pu_q;
  assign done   = done_q;

endmodule
